mac_rx_pkt_buffer_axil: RTL and testbench
=========================================

Name: mac_rx_pkt_buffer_axil

Overview:
- Parametrised successor to the single-buffer MAC RX capture block. Captures whole Ethernet frames from the tri-mode MAC RX FIFO interface into N_SLOTS packet slots, used as a ring.
- Exposes the oldest full slot (head) plus status and counters over AXI4-Lite. Software frees a slot by writing a release register.
- Single clock domain. Sits between the MAC RX user interface and the AXI interconnect.

Parameters:
- DAT_W, 32, MAC data and memory word width in bits; multiple of 8.
- BEN_W, 2, MAC byte-enable width; valid bytes on the last word = mac_ben_i+1, with 2**BEN_W == DAT_W/8.
- ADDR_W, 9, log2 words per slot.
- N_SLOTS, 2, number of packet slots; power of 2, 2..8.
- C_S_AXI_ADDR_WIDTH, 32, AXI address width.
- C_S_AXI_DATA_WIDTH, 32, AXI data width; must equal DAT_W.

Ports:
- ACLK in 1: sole clock.
- ARESETN in 1: reset, synchronous, active-low.
- mac_rxd_i in DAT_W: RX data.
- mac_ben_i in BEN_W: last-word byte enable.
- mac_rxda_i in 1: RX data available.
- mac_rxsop_i in 1: start of packet.
- mac_rxeop_i in 1: end of packet.
- mac_rxdv_i in 1: RX data valid.
- mac_rxrqrd_o out 1: RX read request.
- AXI4-Lite slave, standard directions: S_AXI_AWADDR/AWPROT/AWVALID/AWREADY, WDATA/WSTRB/WVALID/WREADY, BRESP/BVALID/BREADY, ARADDR/ARVALID/ARREADY, RDATA/RRESP/RVALID/RREADY.

Behaviour:
- Reset (ARESETN=0 at a clock edge): all outputs 0; all slots empty; write and read slot pointers 0; pkt_count and drop_count 0. Reset mid-packet abandons the frame, and no partial slot survives.
- Capture FSM states:
  - W_IDLE: if mac_rxda_i and the slot at the write pointer is empty, go to W_REQ. If no slot is free, mac_rxrqrd_o stays 0 (backpressure).
  - W_REQ: capture waits for sop. A dv word without sop is discarded; dv with sop goes to W_CAP and the word is written at index 0.
  - W_CAP: each dv word is written at the next index. The eop word is masked to its low (mac_ben_i+1) bytes; non-eop words are stored unmasked.
    - On dv&eop: store len_bytes = (words-1)*(DAT_W/8) + mac_ben_i + 1 (16-bit), mark the slot full, advance the write pointer mod N_SLOTS, increment pkt_count (32-bit, wraps), go to W_IDLE.
    - If a dv word arrives when the index is already 2**ADDR_W (overflow), go to W_DROP.
  - W_DROP: discard words until dv&eop, then increment drop_count (32-bit, wraps). The slot stays empty and the write pointer does not move; return to W_IDLE.
- mac_rxrqrd_o is registered and equals mac_rxda_i while in W_REQ, W_CAP or W_DROP; otherwise 0.
- Address map (byte addresses, only bits [ADDR_W+2:0] decoded):
  - Data window: bit ADDR_W+2 = 1; word index = ARADDR[ADDR_W+1:2] of the head slot. Default window is 0x800-0xFFF.
  - 0x000 STATUS (RO): [N_SLOTS-1:0] full flags; [18:16] head index; [26:24] write index.
  - 0x004 PKT_LEN (RO): head slot length in bytes, or 0 if the head is empty.
  - 0x008 PKT_COUNT (RO).
  - 0x00C DROP_COUNT (RO).
  - 0x010 RELEASE (WO): any write clears the head full flag and advances the head mod N_SLOTS.
  - Any other address, or nonzero address bits above ADDR_W+2: SLVERR (2'b10), RDATA=0.
  - A data-window read of an empty head: RDATA=0, OKAY.
- Read FSM: R_IDLE -> R_MEM -> R_RESP.
  - R_IDLE: on ARVALID, ARREADY=1 for exactly one cycle; latch the address.
  - R_MEM: registered RAM/register read.
  - R_RESP: RVALID=1 with RDATA/RRESP held stable until RREADY, then R_IDLE.
  - Latency: 2 cycles from the AR handshake to RVALID. One outstanding read.
- Write FSM: W_ADDR -> W_RESP.
  - W_ADDR: waits for AWVALID&&WVALID together; AWREADY=WREADY=1 for one cycle.
  - W_RESP: BVALID held until BREADY.
  - BRESP: OKAY for RELEASE with head full. SLVERR, with no side effect, for RELEASE with head empty, writes to RO registers, and unmapped addresses. WSTRB is ignored.
- Simultaneous events:
  - RELEASE and packet commit in the same cycle both take effect. With N_SLOTS full, a release frees the slot, and capture may start the next cycle.
  - A read of PKT_LEN/STATUS in the commit cycle returns the pre-commit value.

Decomposition:
- Package mac_axi_buf_pkg holds:
  - register offset constants;
  - AXI resp constants OKAY/SLVERR;
  - enums for capture, read and write FSM states.
- Sub-module pkt_slot_ram: simple dual-port, N_SLOTS*2**ADDR_W x DAT_W, one write port, registered read port, ram_style block on Xilinx. The slot index forms the upper address bits.

Test Plan:
- 64-byte frame: 16 words, eop with ben=2'b11 -> STATUS[0]=1, PKT_LEN=64, PKT_COUNT=1, data reads at 0x800..0x83C match, RVALID 2 cycles after AR handshake.
- 61-byte frame: eop ben=2'b00 -> PKT_LEN=61, word 0x83C reads 0x000000XX with only the low byte preserved.
- Three frames with N_SLOTS=2 and no release -> third frame not requested (mac_rxrqrd_o=0). After RELEASE (BRESP=OKAY) the third frame is captured into slot 0, and STATUS head=1.
- 600-word frame (over 512) -> drop_count=1, pkt_count unchanged, slot stays empty. The next 16-word frame is captured normally.
- RELEASE with all slots empty -> BRESP=SLVERR, STATUS unchanged. Read of 0x014 -> RRESP=SLVERR, RDATA=0. Hold RREADY=0 for 5 cycles -> RDATA stable.
- ARESETN low for 1 cycle at word 8 of a frame -> all counters 0, STATUS=0, mac_rxrqrd_o=0. Words before the next sop are ignored.

Source files
------------

// File: rtl/mac_axi_buf_pkg.sv
// Shared constants and FSM state types for the MAC RX packet buffer.
package mac_axi_buf_pkg;

   localparam logic [4:0] REG_STATUS   = 5'h00;
   localparam logic [4:0] REG_PKT_LEN  = 5'h04;
   localparam logic [4:0] REG_PKT_CNT  = 5'h08;
   localparam logic [4:0] REG_DROP_CNT = 5'h0C;
   localparam logic [4:0] REG_RELEASE  = 5'h10;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {W_IDLE, W_REQ, W_CAP, W_DROP} cap_st_e;
   typedef enum logic [1:0] {R_IDLE, R_MEM, R_RESP} rd_st_e;
   typedef enum logic {W_ADDR, W_RESP} wr_st_e;

endpackage

// File: rtl/pkt_slot_ram.sv
// Simple dual-port slot storage; slot index is the upper address bits.
module pkt_slot_ram #(
   parameter int DAT_W = 32,
   parameter int AW    = 10
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [DAT_W-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [DAT_W-1:0] rdata
);

   (* ram_style = "block" *) logic [DAT_W-1:0] mem [2**AW];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      rdata <= mem[raddr];
   end

endmodule

// File: rtl/mac_rx_pkt_buffer_axil.sv
// Captures MAC RX frames into a ring of packet slots; the oldest full slot
// and the status/counter registers are read over AXI4-Lite.
module mac_rx_pkt_buffer_axil
   import mac_axi_buf_pkg::*;
#(
   parameter int DAT_W              = 32,
   parameter int BEN_W              = 2,
   parameter int ADDR_W             = 9,
   parameter int N_SLOTS            = 2,
   parameter int C_S_AXI_ADDR_WIDTH = 32,
   parameter int C_S_AXI_DATA_WIDTH = 32
) (
   input  logic                            ACLK,
   input  logic                            ARESETN,
   input  logic [DAT_W-1:0]                mac_rxd_i,
   input  logic [BEN_W-1:0]                mac_ben_i,
   input  logic                            mac_rxda_i,
   input  logic                            mac_rxsop_i,
   input  logic                            mac_rxeop_i,
   input  logic                            mac_rxdv_i,
   output logic                            mac_rxrqrd_o,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
   input  logic [2:0]                      S_AXI_AWPROT,
   input  logic                            S_AXI_AWVALID,
   output logic                            S_AXI_AWREADY,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
   input  logic                            S_AXI_WVALID,
   output logic                            S_AXI_WREADY,
   output logic [1:0]                      S_AXI_BRESP,
   output logic                            S_AXI_BVALID,
   input  logic                            S_AXI_BREADY,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
   input  logic                            S_AXI_ARVALID,
   output logic                            S_AXI_ARREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
   output logic [1:0]                      S_AXI_RRESP,
   output logic                            S_AXI_RVALID,
   input  logic                            S_AXI_RREADY
);

   localparam int BYTES  = DAT_W / 8;
   localparam int SLOT_W = $clog2(N_SLOTS);
   localparam int LOW_W  = ADDR_W + 3;
   localparam int AW     = C_S_AXI_ADDR_WIDTH;

   cap_st_e            cap_st;
   rd_st_e             rd_st;
   wr_st_e             wr_st;
   logic [SLOT_W-1:0]  wr_ptr, hd_ptr;
   logic [N_SLOTS-1:0] full;
   logic [15:0]        len_q [N_SLOTS];
   logic [ADDR_W:0]    wr_idx;
   logic [31:0]        pkt_count, drop_count;
   logic [AW-1:0]      araddr_q;
   logic [DAT_W-1:0]   ram_q, wr_data, status;
   logic [15:0]        commit_len;
   logic               ovf, first_wr, cap_wr, commit, aw_hs, aw_is_rel, release_ok;
   logic               unused_ok;

   assign unused_ok = ^{S_AXI_AWPROT, S_AXI_WSTRB, S_AXI_WDATA};

   always_comb begin
      ovf        = wr_idx[ADDR_W];
      first_wr   = cap_st == W_REQ && mac_rxdv_i && mac_rxsop_i;
      cap_wr     = first_wr || (cap_st == W_CAP && mac_rxdv_i && !ovf);
      commit     = cap_wr && mac_rxeop_i;
      commit_len = 16'(int'(wr_idx) * BYTES + int'(mac_ben_i) + 1);
      // Only the eop word carries bytes past the frame end; clear them.
      wr_data = mac_rxd_i;
      if (mac_rxeop_i)
         for (int b = 0; b < BYTES; b++)
            if (b > int'(mac_ben_i)) wr_data[b*8 +: 8] = '0;
      aw_hs      = wr_st == W_ADDR && S_AXI_AWREADY && S_AXI_AWVALID && S_AXI_WVALID;
      aw_is_rel  = S_AXI_AWADDR[AW-1:LOW_W] == '0 && S_AXI_AWADDR[LOW_W-1:0] == LOW_W'(REG_RELEASE);
      release_ok = aw_hs && aw_is_rel && full[hd_ptr];
      status = '0;
      status[N_SLOTS-1:0] = full;
      status[18:16]       = 3'(hd_ptr);
      status[26:24]       = 3'(wr_ptr);
   end

   pkt_slot_ram #(.DAT_W(DAT_W), .AW(SLOT_W + ADDR_W)) u_ram (
      .clk   (ACLK),
      .we    (cap_wr),
      .waddr ({wr_ptr, wr_idx[ADDR_W-1:0]}),
      .wdata (wr_data),
      .raddr ({hd_ptr, S_AXI_ARADDR[ADDR_W+1:2]}),
      .rdata (ram_q)
   );

   always_ff @(posedge ACLK) begin
      if (!ARESETN) begin
         cap_st       <= W_IDLE;
         wr_ptr       <= '0;
         wr_idx       <= '0;
         pkt_count    <= '0;
         drop_count   <= '0;
         mac_rxrqrd_o <= 1'b0;
      end else begin
         mac_rxrqrd_o <= mac_rxda_i && cap_st != W_IDLE;
         if (cap_wr) wr_idx <= wr_idx + 1'b1;
         if (commit) begin
            len_q[wr_ptr] <= commit_len;
            wr_ptr        <= wr_ptr + 1'b1;
            pkt_count     <= pkt_count + 32'd1;
         end
         case (cap_st)
            W_IDLE: begin
               wr_idx <= '0;
               if (mac_rxda_i && !full[wr_ptr]) cap_st <= W_REQ;
            end
            W_REQ:  if (first_wr) cap_st <= mac_rxeop_i ? W_IDLE : W_CAP;
            W_CAP:  if (mac_rxdv_i) begin
               if (ovf && mac_rxeop_i) begin
                  drop_count <= drop_count + 32'd1;
                  cap_st     <= W_IDLE;
               end else if (ovf)        cap_st <= W_DROP;
               else if (mac_rxeop_i)    cap_st <= W_IDLE;
            end
            W_DROP: if (mac_rxdv_i && mac_rxeop_i) begin
               drop_count <= drop_count + 32'd1;
               cap_st     <= W_IDLE;
            end
            default: cap_st <= W_IDLE;
         endcase
      end
   end

   // Release and commit never target the same slot, so both may land together.
   always_ff @(posedge ACLK) begin
      if (!ARESETN) begin
         full   <= '0;
         hd_ptr <= '0;
      end else begin
         if (release_ok) begin
            full[hd_ptr] <= 1'b0;
            hd_ptr       <= hd_ptr + 1'b1;
         end
         if (commit) full[wr_ptr] <= 1'b1;
      end
   end

   always_ff @(posedge ACLK) begin
      if (!ARESETN) begin
         rd_st         <= R_IDLE;
         araddr_q      <= '0;
         S_AXI_ARREADY <= 1'b0;
         S_AXI_RVALID  <= 1'b0;
         S_AXI_RDATA   <= '0;
         S_AXI_RRESP   <= RESP_OKAY;
      end else begin
         case (rd_st)
            R_IDLE: if (S_AXI_ARREADY && S_AXI_ARVALID) begin
               S_AXI_ARREADY <= 1'b0;
               araddr_q      <= S_AXI_ARADDR;
               rd_st         <= R_MEM;
            end else if (S_AXI_ARVALID) S_AXI_ARREADY <= 1'b1;
            R_MEM: begin
               S_AXI_RVALID <= 1'b1;
               S_AXI_RRESP  <= RESP_OKAY;
               S_AXI_RDATA  <= '0;
               rd_st        <= R_RESP;
               if (araddr_q[AW-1:LOW_W] != '0) S_AXI_RRESP <= RESP_SLVERR;
               else if (araddr_q[LOW_W-1])     S_AXI_RDATA <= full[hd_ptr] ? ram_q : '0;
               else case (araddr_q[LOW_W-1:0])
                  LOW_W'(REG_STATUS):   S_AXI_RDATA <= status;
                  LOW_W'(REG_PKT_LEN):  S_AXI_RDATA <= DAT_W'(full[hd_ptr] ? len_q[hd_ptr] : 16'd0);
                  LOW_W'(REG_PKT_CNT):  S_AXI_RDATA <= pkt_count;
                  LOW_W'(REG_DROP_CNT): S_AXI_RDATA <= drop_count;
                  default:              S_AXI_RRESP <= RESP_SLVERR;
               endcase
            end
            R_RESP: if (S_AXI_RREADY) begin
               S_AXI_RVALID <= 1'b0;
               rd_st        <= R_IDLE;
            end
            default: rd_st <= R_IDLE;
         endcase
      end
   end

   always_ff @(posedge ACLK) begin
      if (!ARESETN) begin
         wr_st         <= W_ADDR;
         S_AXI_AWREADY <= 1'b0;
         S_AXI_WREADY  <= 1'b0;
         S_AXI_BVALID  <= 1'b0;
         S_AXI_BRESP   <= RESP_OKAY;
      end else begin
         case (wr_st)
            W_ADDR: if (aw_hs) begin
               S_AXI_AWREADY <= 1'b0;
               S_AXI_WREADY  <= 1'b0;
               S_AXI_BVALID  <= 1'b1;
               S_AXI_BRESP   <= release_ok ? RESP_OKAY : RESP_SLVERR;
               wr_st         <= W_RESP;
            end else if (S_AXI_AWVALID && S_AXI_WVALID) begin
               S_AXI_AWREADY <= 1'b1;
               S_AXI_WREADY  <= 1'b1;
            end
            W_RESP: if (S_AXI_BREADY) begin
               S_AXI_BVALID <= 1'b0;
               wr_st        <= W_ADDR;
            end
            default: wr_st <= W_ADDR;
         endcase
      end
   end

endmodule

// File: tb/tb_mac_rx_pkt_buffer_axil.sv
// Directed/random bench for mac_rx_pkt_buffer_axil against a frame-level slot model.
module tb_mac_rx_pkt_buffer_axil;

   localparam int N_SLOTS = 2;
   localparam logic [31:0] A_STATUS = 32'h000, A_LEN = 32'h004, A_PKT = 32'h008,
                           A_DROP = 32'h00C, A_REL = 32'h010, A_DATA = 32'h800;

   typedef byte unsigned bq_t[$];

   logic        ACLK = 0, ARESETN;
   logic [31:0] mac_rxd_i;
   logic [1:0]  mac_ben_i;
   logic        mac_rxda_i, mac_rxsop_i, mac_rxeop_i, mac_rxdv_i, mac_rxrqrd_o;
   logic [31:0] S_AXI_AWADDR, S_AXI_WDATA, S_AXI_ARADDR, S_AXI_RDATA;
   logic [2:0]  S_AXI_AWPROT;
   logic [3:0]  S_AXI_WSTRB;
   logic [1:0]  S_AXI_BRESP, S_AXI_RRESP;
   logic        S_AXI_AWVALID, S_AXI_AWREADY, S_AXI_WVALID, S_AXI_WREADY, S_AXI_BVALID, S_AXI_BREADY;
   logic        S_AXI_ARVALID, S_AXI_ARREADY, S_AXI_RVALID, S_AXI_RREADY;

   int errors = 0, checks = 0;

   // Frame-level model: one byte queue per slot, ring pointers and counters.
   bq_t         m_slot [N_SLOTS];
   bit          m_full [N_SLOTS];
   int          m_head, m_wr;
   int unsigned m_pkt, m_drop;

   mac_rx_pkt_buffer_axil dut (
      .ACLK(ACLK), .ARESETN(ARESETN),
      .mac_rxd_i(mac_rxd_i), .mac_ben_i(mac_ben_i), .mac_rxda_i(mac_rxda_i),
      .mac_rxsop_i(mac_rxsop_i), .mac_rxeop_i(mac_rxeop_i), .mac_rxdv_i(mac_rxdv_i),
      .mac_rxrqrd_o(mac_rxrqrd_o),
      .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT), .S_AXI_AWVALID(S_AXI_AWVALID),
      .S_AXI_AWREADY(S_AXI_AWREADY), .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
      .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY), .S_AXI_BRESP(S_AXI_BRESP),
      .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY), .S_AXI_ARADDR(S_AXI_ARADDR),
      .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY), .S_AXI_RDATA(S_AXI_RDATA),
      .S_AXI_RRESP(S_AXI_RRESP), .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY)
   );

   always #5 ACLK = ~ACLK;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic void model_reset();
      for (int i = 0; i < N_SLOTS; i++) begin m_full[i] = 0; m_slot[i] = {}; end
      m_head = 0; m_wr = 0; m_pkt = 0; m_drop = 0;
   endfunction

   function automatic void model_accept(input bq_t f);
      if ((f.size() + 3) / 4 > 512) m_drop++;
      else begin
         m_slot[m_wr] = f; m_full[m_wr] = 1;
         m_wr = (m_wr + 1) % N_SLOTS; m_pkt++;
      end
   endfunction

   function automatic logic [1:0] model_release();
      if (!m_full[m_head]) return 2'b10;
      m_full[m_head] = 0; m_head = (m_head + 1) % N_SLOTS;
      return 2'b00;
   endfunction

   function automatic logic [31:0] exp_status();
      logic [31:0] s = '0;
      for (int i = 0; i < N_SLOTS; i++) s[i] = m_full[i];
      s[18:16] = 3'(m_head);
      s[26:24] = 3'(m_wr);
      return s;
   endfunction

   function automatic logic [31:0] exp_len();
      return m_full[m_head] ? 32'(m_slot[m_head].size()) : 32'd0;
   endfunction

   function automatic logic [31:0] exp_word(input int i);
      logic [31:0] w = '0;
      if (m_full[m_head])
         for (int b = 0; b < 4; b++)
            if (4*i + b < m_slot[m_head].size()) w[8*b +: 8] = m_slot[m_head][4*i + b];
      return w;
   endfunction

   function automatic bq_t make_frame(input int n);
      bq_t q;
      for (int i = 0; i < n; i++) q.push_back(8'($urandom));
      return q;
   endfunction

   task automatic axi_read(input logic [31:0] addr, input int hold,
                           output logic [31:0] data, output logic [1:0] resp);
      int t = 0, lat = 1;
      S_AXI_ARADDR = addr; S_AXI_ARVALID = 1; S_AXI_RREADY = 0;
      @(negedge ACLK);
      while (!S_AXI_ARREADY && t < 20) begin @(negedge ACLK); t++; end
      chk("arready", S_AXI_ARREADY, 1);
      @(negedge ACLK);
      S_AXI_ARVALID = 0;
      while (!S_AXI_RVALID && lat < 20) begin @(negedge ACLK); lat++; end
      chk("rd_latency", lat, 2);
      data = S_AXI_RDATA; resp = S_AXI_RRESP;
      repeat (hold) @(negedge ACLK);
      if (hold > 0) begin
         chk("rvalid_held", S_AXI_RVALID, 1);
         chk("rdata_stable", S_AXI_RDATA, data);
         chk("rresp_stable", S_AXI_RRESP, resp);
      end
      S_AXI_RREADY = 1;
      @(negedge ACLK);
      S_AXI_RREADY = 0;
      chk("rvalid_done", S_AXI_RVALID, 0);
   endtask

   task automatic axi_write(input logic [31:0] addr, output logic [1:0] resp);
      int t = 0;
      S_AXI_AWADDR = addr; S_AXI_WDATA = $urandom; S_AXI_WSTRB = 4'($urandom);
      S_AXI_AWVALID = 1; S_AXI_WVALID = 1; S_AXI_BREADY = 0;
      @(negedge ACLK);
      while (!(S_AXI_AWREADY && S_AXI_WREADY) && t < 20) begin @(negedge ACLK); t++; end
      chk("aw_w_ready", S_AXI_AWREADY & S_AXI_WREADY, 1);
      @(negedge ACLK);
      S_AXI_AWVALID = 0; S_AXI_WVALID = 0; t = 0;
      while (!S_AXI_BVALID && t < 20) begin @(negedge ACLK); t++; end
      chk("bvalid", S_AXI_BVALID, 1);
      resp = S_AXI_BRESP;
      S_AXI_BREADY = 1;
      @(negedge ACLK);
      S_AXI_BREADY = 0;
   endtask

   task automatic release_head();
      logic [1:0] exp_r, r;
      exp_r = model_release();
      axi_write(A_REL, r);
      chk("release_bresp", r, exp_r);
   endtask

   task automatic check_regs(input string tag);
      logic [31:0] d; logic [1:0] r;
      axi_read(A_STATUS, 0, d, r); chk({tag, "_status"}, d, exp_status());
      axi_read(A_LEN, 0, d, r);    chk({tag, "_len"}, d, exp_len());
      axi_read(A_PKT, 0, d, r);    chk({tag, "_pkt"}, d, m_pkt);
      axi_read(A_DROP, 0, d, r);   chk({tag, "_drop"}, d, m_drop);
      chk({tag, "_rresp"}, r, 2'b00);
   endtask

   task automatic check_data(input int nwords);
      logic [31:0] d; logic [1:0] r;
      for (int i = 0; i < nwords; i++) begin
         axi_read(A_DATA + 32'(4*i), 0, d, r);
         chk($sformatf("data[%0d]", i), d, exp_word(i));
      end
   endtask

   // Drives one frame; abort_at >= 0 pulses reset after that word instead of finishing.
   task automatic send_frame(input bq_t f, input int n_junk, input int abort_at,
                             input int req_wait, output bit requested);
      int nw = (f.size() + 3) / 4;
      int t = 0;
      logic [31:0] w;
      mac_rxda_i = 1;
      while (!mac_rxrqrd_o && t < req_wait) begin @(negedge ACLK); t++; end
      requested = mac_rxrqrd_o;
      if (!requested) return;
      repeat (n_junk) begin
         mac_rxd_i = $urandom; mac_rxdv_i = 1; mac_rxsop_i = 0; mac_rxeop_i = 0;
         @(negedge ACLK);
      end
      for (int wi = 0; wi < nw; wi++) begin
         if ($urandom_range(0, 3) == 0) begin mac_rxdv_i = 0; @(negedge ACLK); end
         w = $urandom;
         for (int b = 0; b < 4; b++)
            if (4*wi + b < f.size()) w[8*b +: 8] = f[4*wi + b];
         mac_rxd_i = w; mac_rxdv_i = 1;
         mac_rxsop_i = (wi == 0); mac_rxeop_i = (wi == nw - 1);
         mac_ben_i = (wi == nw - 1) ? 2'((f.size() - 1) % 4) : 2'($urandom);
         @(negedge ACLK);
         if (wi == abort_at) begin
            ARESETN = 0; mac_rxdv_i = 0; mac_rxsop_i = 0; mac_rxeop_i = 0; mac_rxda_i = 0;
            @(negedge ACLK);
            return;
         end
      end
      mac_rxdv_i = 0; mac_rxsop_i = 0; mac_rxeop_i = 0; mac_rxda_i = 0;
      @(negedge ACLK);
   endtask

   initial begin
      bq_t f, fa, fb, fc;
      bit req;
      logic [31:0] d;
      logic [1:0] r;

      ARESETN = 0;
      mac_rxd_i = '0; mac_ben_i = '0; mac_rxda_i = 0; mac_rxsop_i = 0; mac_rxeop_i = 0; mac_rxdv_i = 0;
      S_AXI_AWADDR = '0; S_AXI_AWPROT = '0; S_AXI_AWVALID = 0; S_AXI_WDATA = '0; S_AXI_WSTRB = '0;
      S_AXI_WVALID = 0; S_AXI_BREADY = 0; S_AXI_ARADDR = '0; S_AXI_ARVALID = 0; S_AXI_RREADY = 0;
      model_reset();
      repeat (3) @(negedge ACLK);
      chk("rst_rqrd", mac_rxrqrd_o, 0);
      chk("rst_ready", {S_AXI_ARREADY, S_AXI_AWREADY, S_AXI_WREADY}, 0);
      chk("rst_valid", {S_AXI_RVALID, S_AXI_BVALID}, 0);
      chk("rst_rdata", S_AXI_RDATA, 0);
      ARESETN = 1;
      @(negedge ACLK);
      check_regs("reset");

      // 64-byte frame, full last word
      f = make_frame(64);
      send_frame(f, 0, -1, 50, req); chk("req64", req, 1); model_accept(f);
      check_regs("f64"); check_data(16);
      release_head();

      // 61-byte frame, one valid byte in the last word
      f = make_frame(61);
      send_frame(f, 1, -1, 50, req); chk("req61", req, 1); model_accept(f);
      check_regs("f61"); check_data(16);
      axi_read(A_DATA + 32'h3C, 0, d, r); chk("w15_upper_zero", d[31:8], 0);
      release_head();

      // Fill both slots, third frame must be held off until a release
      fa = make_frame(40); fb = make_frame(33); fc = make_frame(20);
      send_frame(fa, 0, -1, 50, req); model_accept(fa);
      send_frame(fb, 0, -1, 50, req); model_accept(fb);
      send_frame(fc, 0, -1, 20, req);
      chk("bp_not_requested", req, 0);
      chk("bp_rqrd", mac_rxrqrd_o, 0);
      check_regs("bp_full");
      release_head();
      send_frame(fc, 0, -1, 50, req); chk("bp_req_after_rel", req, 1); model_accept(fc);
      check_regs("bp_third"); check_data(9);
      release_head(); check_data(5);
      release_head();

      // Oversized frame is dropped, next frame captured normally
      f = make_frame(2400);
      send_frame(f, 0, -1, 50, req); model_accept(f);
      check_regs("drop");
      f = make_frame(64);
      send_frame(f, 0, -1, 50, req); model_accept(f);
      check_regs("after_drop"); check_data(16);
      release_head();

      // Error responses with an empty buffer
      release_head();
      check_regs("empty_rel");
      axi_read(32'h014, 5, d, r);   chk("unmapped_resp", r, 2'b10); chk("unmapped_data", d, 0);
      axi_read(A_DATA, 0, d, r);    chk("empty_data_resp", r, 2'b00); chk("empty_data", d, 0);
      axi_read(32'h1000, 0, d, r);  chk("high_addr_resp", r, 2'b10);
      axi_write(A_PKT, r);          chk("ro_write_resp", r, 2'b10);

      // Random frames with junk before sop and idle gaps
      for (int k = 0; k < 6; k++) begin
         f = make_frame($urandom_range(1, 200));
         send_frame(f, $urandom_range(0, 2), -1, 50, req); chk("rand_req", req, 1); model_accept(f);
         check_regs("rand"); check_data((f.size() + 3) / 4);
         release_head();
      end

      // Reset in the middle of a frame
      f = make_frame(64);
      send_frame(f, 0, 8, 50, req);
      chk("midrst_rqrd", mac_rxrqrd_o, 0);
      ARESETN = 1;
      model_reset();
      @(negedge ACLK);
      check_regs("midrst");
      f = make_frame(48);
      send_frame(f, 3, -1, 50, req); model_accept(f);
      check_regs("post_rst"); check_data(12);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
